// File: rtl/axi_miss_refill_if.sv
// AXI4 read-address and read-data channels between the refill engine and memory.
// The engine is the master; the interconnect or memory model is the slave.
interface axi_miss_refill_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
);
    logic              m_axi_arvalid;
    logic              m_axi_arready;
    logic [ADDR_W-1:0] m_axi_araddr;
    logic [7:0]        m_axi_arlen;
    logic [2:0]        m_axi_arsize;
    logic [1:0]        m_axi_arburst;
    logic              m_axi_rvalid;
    logic              m_axi_rready;
    logic [DATA_W-1:0] m_axi_rdata;
    logic [1:0]        m_axi_rresp;
    logic              m_axi_rlast;

    modport master (
        output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        output m_axi_rready,
        input  m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast
    );

    modport slave (
        input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        input  m_axi_rready,
        output m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast
    );
endinterface

// File: rtl/axi_miss_refill.sv
// Cache-line refill engine: serialises lane 1 / lane 2 misses into single AXI4 INCR
// read bursts and streams the returned beats into the requesting lane's cache.
module axi_miss_refill #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned LINE_BEATS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          miss1_i,
    input  logic [ADDR_W-1:0]             miss_addr1_i,
    input  logic                          miss2_i,
    input  logic [ADDR_W-1:0]             miss_addr2_i,
    output logic                          Stall_miss1,
    output logic                          Stall_miss2,
    output logic                          fill_we,
    output logic                          fill_lane,
    output logic [$clog2(LINE_BEATS)-1:0] fill_beat,
    output logic [DATA_W-1:0]             fill_data,
    output logic                          fill_done,
    output logic                          fill_err,
    axi_miss_refill_if.master             axi
);
    localparam int unsigned BeatW = $clog2(LINE_BEATS);
    localparam int unsigned OffW  = $clog2(LINE_BEATS * DATA_W / 8);
    localparam logic [BeatW-1:0]  LastBeat = BeatW'(LINE_BEATS - 1);
    localparam logic [ADDR_W-1:0] LineMask = ~ADDR_W'((64'd1 << OffW) - 64'd1);

    typedef enum logic [1:0] {StIdle, StAr, StR, StDone} state_e;

    state_e            state_q, state_d;
    logic              cur_lane_q, cur_lane_d;
    logic [ADDR_W-1:0] line_addr_q, line_addr_d;
    logic [BeatW-1:0]  beat_cnt_q, beat_cnt_d;
    logic              err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cur_lane_q  <= 1'b0;
            line_addr_q <= '0;
            beat_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_lane_q  <= cur_lane_d;
            line_addr_q <= line_addr_d;
            beat_cnt_q  <= beat_cnt_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_lane_d  = cur_lane_q;
        line_addr_d = line_addr_q;
        beat_cnt_d  = beat_cnt_q;
        err_d       = err_q;
        unique case (state_q)
            StIdle: begin
                beat_cnt_d = '0;
                err_d      = 1'b0;
                // Lane 1 holds the older instruction, so it wins a simultaneous miss.
                if (miss1_i) begin
                    cur_lane_d  = 1'b0;
                    line_addr_d = miss_addr1_i & LineMask;
                    state_d     = StAr;
                end else if (miss2_i) begin
                    cur_lane_d  = 1'b1;
                    line_addr_d = miss_addr2_i & LineMask;
                    state_d     = StAr;
                end
            end
            StAr: begin
                if (axi.m_axi_arready) state_d = StR;
            end
            StR: begin
                if (axi.m_axi_rvalid) begin
                    // Saturate: surplus beats before rlast overwrite the last index.
                    if (beat_cnt_q != LastBeat) beat_cnt_d = beat_cnt_q + 1'b1;
                    err_d = err_q | (axi.m_axi_rresp != 2'b00);
                    if (axi.m_axi_rlast) state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign axi.m_axi_arvalid = (state_q == StAr);
    assign axi.m_axi_araddr  = line_addr_q;
    assign axi.m_axi_arlen   = 8'(LINE_BEATS - 1);
    assign axi.m_axi_arsize  = 3'($clog2(DATA_W / 8));
    assign axi.m_axi_arburst = 2'b01;
    assign axi.m_axi_rready  = (state_q == StR);

    assign fill_we   = (state_q == StR) && axi.m_axi_rvalid;
    assign fill_lane = cur_lane_q;
    assign fill_beat = beat_cnt_q;
    assign fill_data = axi.m_axi_rdata;
    assign fill_done = (state_q == StDone);
    assign fill_err  = (state_q == StDone) && err_q;

    assign Stall_miss1 = miss1_i && !((state_q == StDone) && !cur_lane_q);
    assign Stall_miss2 = miss2_i && !((state_q == StDone) && cur_lane_q);
endmodule
